mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single four-bank main memory between two cache controllers: port 0 (I-cache FSM), port 1 (D-cache FSM).
//  Grants are locked for a whole burst (line fill or evict) and assigned round-robin.
//  The block forwards the owner's word accesses to memory, stalls on bank conflicts and routes read returns to the issuing port.
// PARAMETERS
//  MEM_LAT   2   cycles from accepted fm_rd to data on m_data_out (>=1)
//  MAX_HOLD  64  owner hold cycles, while the other port waits, before err is flagged
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  req0/req1  in   1   port requests bus ownership; held high for the whole burst
//  rd0/rd1    in   1   word read this cycle
//  wr0/wr1    in   1   word write this cycle
//  addr0/1    in   16  word address; bank = addr[2:1]
//  wdata0/1   in   16  write data
//  gnt0/gnt1  out  1   port owns memory (registered)
//  stall0/1   out  1   rd/wr not accepted this cycle; port holds and retries
//  rvalid0/1  out  1   read data valid for that port (registered from the return pipe)
//  rdata0/1   out  16  = m_data_out when the matching rvalid is high, else 0
//  fm_addr    out  16  memory address
//  fm_data_in out  16  memory write data
//  fm_rd/fm_wr out 1   memory strobes
//  m_data_out in   16  memory read data
//  m_stall    in   1   memory globally stalled
//  m_busy     in   4   per-bank busy
//  m_err      in   1   memory error
//  err        out  1   m_err | protocol error | watchdog
// BEHAVIOUR
//  Reset: state IDLE, last=1 (port 0 wins the first tie), read pipe and hold counter cleared, all outputs 0.
//  States: IDLE, OWN0, OWN1, DRAIN.
//  IDLE:
//   - only reqN -> OWNN
//   - both -> OWN of the port != last; last updated on grant
//   - neither -> stay
//   - gntN rises the cycle after the request is seen (1-cycle grant latency)
//  OWNn:
//   - owner rd xor wr forwarded combinationally: fm_addr = addr, fm_data_in = wdata
//   - blocked = m_stall | m_busy[addr[2:1]]; when blocked: fm_rd = fm_wr = 0, stallN = 1
//   - accepted rd pushes {1,n} into the return pipe
//   - owner rd & wr together -> err pulse; no memory op; stall = 1
//  Release (owner drops req):
//   - pipe empty -> IDLE (one bubble cycle before the next grant)
//   - pipe not empty -> DRAIN
//   - gnt drops the same edge
//  DRAIN: no new accesses; -> IDLE on the cycle the pipe is empty.
//  Non-owner rd/wr: stall = 1, never forwarded. rd/wr with its own req low: err pulse.
//  Read return: the entry reaches the pipe tail exactly MEM_LAT cycles after acceptance; rvalidN = 1 for the tagged port only.
//   Returns keep the tag from issue time, including during DRAIN.
//  Watchdog: counts owner cycles while the other req is high and ungranted.
//   At MAX_HOLD, err goes high and stays high until release. No preemption.
//  Reset mid-burst: grant lost, in-flight returns dropped (no rvalid).
//  err is combinational. m_err is passed through in every state.
// STRUCTURE
//  Package mem_arb_pkg:
//   - state encodings (IDLE=2'd0, OWN0=1, OWN1=2, DRAIN=3)
//   - PORT_I=0, PORT_D=1
//   - bank-select slice constants
//  Sub-module mem_rd_pipe: MEM_LAT-deep shift register of {valid, port}, with an empty flag.
//  Everything else (FSM, arbitration, muxing, watchdog) stays in this module.
// TESTING
//  1. req0 alone; rd0 at 0x0010, 0x0012, 0x0014, 0x0016 on consecutive cycles, m_busy=0
//     -> gnt0 after 1 cycle; four fm_rd; rvalid0 at issue+2 each; rvalid1 stays 0.
//  2. req0 and req1 rise together after reset -> gnt0. Release, then both again -> gnt1 (round-robin), with one IDLE cycle between.
//  3. Owner wr0 to 0x0102 with m_busy=4'b0010 for 3 cycles
//     -> stall0 high for 3 cycles with fm_wr=0; accepted on the 4th cycle with fm_data_in = wdata0.
//  4. Owner 1 issues a read, then drops req1 the next cycle
//     -> DRAIN; rvalid1 at issue+2; then IDLE; a pending req0 is granted afterwards.
//  5. Owner issues rd1 & wr1 together -> err for 1 cycle, no strobe. Non-owner rd0 -> stall0, no memory op.
//  6. Port 0 holds 64 cycles with req1 high -> err from cycle 64 until release.
//     Separately, assert rst mid-burst -> all outputs 0 immediately, no late rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int NBANK  = 4;

   // port indices: I-cache on 0, D-cache on 1
   localparam int PORT_I = 0;
   localparam int PORT_D = 1;

   // bank select is the word address slice [2:1]
   localparam int BANK_LO = 1;
   localparam int BANK_HI = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   // one slot of the read-return pipe
   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   // cache-controller side
   logic              req0, req1;
   logic              rd0, rd1;
   logic              wr0, wr1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              stall0, stall1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;

   // memory side
   logic [ADDR_W-1:0] fm_addr;
   logic [DATA_W-1:0] fm_data_in;
   logic              fm_rd, fm_wr;
   logic [DATA_W-1:0] m_data_out;
   logic              m_stall;
   logic [NBANK-1:0]  m_busy;
   logic              m_err;

   logic              err;

   // arbiter view
   modport slave (
      input  req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1,
      input  m_data_out, m_stall, m_busy, m_err,
      output gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, rdata0, rdata1,
      output fm_addr, fm_data_in, fm_rd, fm_wr, err
   );

   // driver view (caches + memory model)
   modport master (
      output req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1,
      output m_data_out, m_stall, m_busy, m_err,
      input  gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, rdata0, rdata1,
      input  fm_addr, fm_data_in, fm_rd, fm_wr, err
   );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read-return tracker: one {valid, port} slot per cycle of memory latency.
// An accepted read enters stage 0 and sits in the tail exactly LAT cycles later,
// which is when memory presents its data.
module mem_rd_pipe
   import mem_arb_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_port,
   output logic tail_vld,
   output logic tail_port,
   output logic empty
);

   rd_tag_t [LAT-1:0] stage;

   // shift one slot per cycle; stage 0 captures this cycle's accepted read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= '{valid: push, port: push_port};
         for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
   end

   // nothing in flight when no slot holds a live entry
   always_comb begin
      empty = 1'b1;
      for (int i = 0; i < LAT; i++)
         if (stage[i].valid) empty = 1'b0;
   end

   assign tail_vld  = stage[LAT-1].valid;
   assign tail_port = stage[LAT-1].port;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port main-memory arbiter: burst-locked round-robin grant, combinational
// forwarding of the owner's word accesses, bank-conflict stalls, tagged read
// returns and an owner-hold watchdog.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT  = 2,
   parameter int MAX_HOLD = 64
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int            HW       = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   arb_state_t state, nxt;
   logic       last;
   logic [HW-1:0] hold_cnt;

   logic [1:0]             req, rd, wr;
   logic [1:0][ADDR_W-1:0] addr;
   logic [1:0][DATA_W-1:0] wdata;

   logic [1:0] own, act, op, blocked, acc, stall, perr, rvalid;
   logic       push_vld, push_port, pipe_empty, tail_vld, tail_port;
   logic       wait_other, wd_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              mem_rd, mem_wr;

   assign req   = {bus.req1, bus.req0};
   assign rd    = {bus.rd1, bus.rd0};
   assign wr    = {bus.wr1, bus.wr0};
   assign addr  = {bus.addr1, bus.addr0};
   assign wdata = {bus.wdata1, bus.wdata0};

   // grant is a decode of the state register; the owner is active while its req holds
   assign own = {state == OWN1, state == OWN0};
   assign act = own & req;

   for (genvar p = 0; p < 2; p++) begin : g_port
      assign op[p]      = act[p] & (rd[p] ^ wr[p]);
      assign blocked[p] = bus.m_stall | bus.m_busy[addr[p][BANK_HI:BANK_LO]];
      assign acc[p]     = op[p] & ~blocked[p];
      // any rd/wr that memory does not take this cycle must be retried
      assign stall[p]   = ~rst & (rd[p] | wr[p]) & ~acc[p];
      // owner asking rd and wr at once, or an access with no request behind it
      assign perr[p]    = (act[p] & rd[p] & wr[p]) | ((rd[p] | wr[p]) & ~req[p]);
      assign rvalid[p]  = tail_vld & (tail_port == 1'(p));
   end

   assign push_vld  = |(acc & rd);
   assign push_port = acc[PORT_D];

   mem_rd_pipe #(.LAT(MEM_LAT)) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vld),
      .push_port (push_port),
      .tail_vld  (tail_vld),
      .tail_port (tail_port),
      .empty     (pipe_empty)
   );

   // state register and round-robin pointer (last = most recently granted port)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= nxt;
         if (state == IDLE && nxt == OWN0)      last <= 1'b0;
         else if (state == IDLE && nxt == OWN1) last <= 1'b1;
      end
   end

   // next state: grant from IDLE, release to IDLE or DRAIN, drain until no returns pending
   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (req[0] && req[1]) nxt = last ? OWN0 : OWN1;
            else if (req[0])      nxt = OWN0;
            else if (req[1])      nxt = OWN1;
         end
         OWN0:    if (!req[0]) nxt = pipe_empty ? IDLE : DRAIN;
         OWN1:    if (!req[1]) nxt = pipe_empty ? IDLE : DRAIN;
         DRAIN:   if (pipe_empty) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // outputs: forward the owner's single access; strobes only when memory can take it
   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      for (int p = 0; p < 2; p++) begin
         if (op[p]) begin
            mem_addr = addr[p];
            mem_din  = wdata[p];
            mem_rd   = acc[p] & rd[p];
            mem_wr   = acc[p] & wr[p];
         end
      end
   end

   // watchdog: owner cycles spent while the other port waits, saturating; cleared once ownership ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      hold_cnt <= '0;
      else if (~|own)                               hold_cnt <= '0;
      else if (wait_other && hold_cnt != HOLD_MAX)  hold_cnt <= hold_cnt + HW'(1);
   end

   assign wait_other = (act[0] & req[1]) | (act[1] & req[0]);
   assign wd_err     = (|act) & (hold_cnt == HOLD_MAX);

   assign bus.gnt0       = own[PORT_I];
   assign bus.gnt1       = own[PORT_D];
   assign bus.stall0     = stall[PORT_I];
   assign bus.stall1     = stall[PORT_D];
   assign bus.rvalid0    = rvalid[PORT_I];
   assign bus.rvalid1    = rvalid[PORT_D];
   assign bus.rdata0     = rvalid[PORT_I] ? bus.m_data_out : '0;
   assign bus.rdata1     = rvalid[PORT_D] ? bus.m_data_out : '0;
   assign bus.fm_addr    = mem_addr;
   assign bus.fm_data_in = mem_din;
   assign bus.fm_rd      = mem_rd;
   assign bus.fm_wr      = mem_wr;
   assign bus.err        = ~rst & (bus.m_err | (|perr) | wd_err);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model (owner, round-robin
// pointer, queue of reads with due cycles, hold count) predicts every output each
// cycle; literal checks at key points pin the model itself.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int MEM_LAT  = 2;
   localparam int MAX_HOLD = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, fm_rd, fm_wr, err;
      logic [15:0] fm_addr, fm_data_in, rdata0, rdata1;
   } obs_t;

   typedef struct { int port; int due; } ret_t;

   // model state
   ret_t pend[$];
   int   m_own   = -1;
   int   m_last  = 1;
   int   m_hold  = 0;
   bit   m_drain = 1'b0;
   int   cyc     = 0;
   int   dval    = 0;

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   // expected outputs for the current cycle from the model state and current inputs
   function automatic obs_t model_out();
      obs_t        e;
      logic [1:0]  rq, r, w;
      logic [15:0] ad [2];
      logic [15:0] wd [2];
      bit          perr, wdg;
      e = '0; perr = 1'b0; wdg = 1'b0;
      rq = {bus.req1, bus.req0};
      r  = {bus.rd1, bus.rd0};
      w  = {bus.wr1, bus.wr0};
      ad[0] = bus.addr0;  ad[1] = bus.addr1;
      wd[0] = bus.wdata0; wd[1] = bus.wdata1;
      if (rst) return e;
      e.gnt0 = (m_own == 0);
      e.gnt1 = (m_own == 1);
      for (int p = 0; p < 2; p++) begin
         bit act, blk, acc, stl;
         act = (m_own == p) && rq[p];
         blk = bus.m_stall || bus.m_busy[ad[p][2:1]];
         acc = act && (r[p] != w[p]) && !blk;
         if (act && (r[p] != w[p])) begin
            e.fm_addr    = ad[p];
            e.fm_data_in = wd[p];
         end
         if (acc) begin
            e.fm_rd = r[p];
            e.fm_wr = w[p];
         end
         stl = (r[p] || w[p]) && !acc;
         if (p == 0) e.stall0 = stl; else e.stall1 = stl;
         if ((act && r[p] && w[p]) || ((r[p] || w[p]) && !rq[p])) perr = 1'b1;
         if (act && m_hold >= MAX_HOLD) wdg = 1'b1;
      end
      foreach (pend[i])
         if (pend[i].due == cyc) begin
            if (pend[i].port == 0) e.rvalid0 = 1'b1; else e.rvalid1 = 1'b1;
         end
      e.rdata0 = e.rvalid0 ? bus.m_data_out : 16'h0;
      e.rdata1 = e.rvalid1 ? bus.m_data_out : 16'h0;
      e.err    = bus.m_err || perr || wdg;
      return e;
   endfunction

   // model update on each clock (or at reset)
   always @(posedge clk or posedge rst) begin
      obs_t       e;
      bit         empty;
      logic [1:0] rq;
      if (rst) begin
         m_own = -1; m_drain = 1'b0; m_last = 1; m_hold = 0;
         pend.delete();
      end else begin
         e     = model_out();
         rq    = {bus.req1, bus.req0};
         empty = (pend.size() == 0);
         if (e.fm_rd) pend.push_back('{m_own, cyc + MEM_LAT});
         while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
         if (m_own >= 0) begin
            if (rq[m_own] && rq[1 - m_own] && m_hold < MAX_HOLD) m_hold++;
            if (!rq[m_own]) begin
               m_drain = !empty;
               m_own   = -1;
               m_hold  = 0;
            end
         end else if (m_drain) begin
            if (empty) m_drain = 1'b0;
         end else if (rq != 2'b00) begin
            m_own  = (rq == 2'b11) ? 1 - m_last : (rq[0] ? 0 : 1);
            m_last = m_own;
            m_hold = 0;
         end
         cyc++;
      end
   end

   // compare every cycle, mid-cycle
   always @(negedge clk) begin
      obs_t       e;
      logic [8:0] got_f, exp_f;
      e = model_out();
      got_f = {bus.gnt0, bus.gnt1, bus.stall0, bus.stall1, bus.rvalid0, bus.rvalid1,
               bus.fm_rd, bus.fm_wr, bus.err};
      exp_f = {e.gnt0, e.gnt1, e.stall0, e.stall1, e.rvalid0, e.rvalid1,
               e.fm_rd, e.fm_wr, e.err};
      check("flags", 16'(got_f), 16'(exp_f));
      check("fm_addr", bus.fm_addr, e.fm_addr);
      check("fm_data_in", bus.fm_data_in, e.fm_data_in);
      check("rdata0", bus.rdata0, e.rdata0);
      check("rdata1", bus.rdata1, e.rdata1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      dval++;
      bus.m_data_out = 16'hD000 + 16'(dval);
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic clear_ops();
      bus.rd0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.rd1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
      bus.m_stall = 0; bus.m_busy = '0; bus.m_err = 0;
   endtask

   task automatic do_reset();
      bus.req0 = 0; bus.req1 = 0;
      clear_ops();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus.req0 = 0; bus.req1 = 0; bus.m_data_out = '0;
      clear_ops();
      tick(); tick();
      at_neg();
      check("rst_gnt0", 16'(bus.gnt0), 16'h0);
      check("rst_err", 16'(bus.err), 16'h0);
      rst = 1'b0;
      tick();

      // 1: single owner, four back-to-back reads
      do_reset();
      bus.req0 = 1;
      at_neg(); check("t1_no_gnt_yet", 16'(bus.gnt0), 16'h0);
      tick();
      bus.rd0 = 1; bus.addr0 = 16'h0010;
      at_neg();
      check("t1_gnt0", 16'(bus.gnt0), 16'h1);
      check("t1_fm_rd", 16'(bus.fm_rd), 16'h1);
      check("t1_fm_addr", bus.fm_addr, 16'h0010);
      tick(); bus.addr0 = 16'h0012;
      tick(); bus.addr0 = 16'h0014;
      at_neg();
      check("t1_rvalid0", 16'(bus.rvalid0), 16'h1);
      check("t1_rvalid1", 16'(bus.rvalid1), 16'h0);
      tick(); bus.addr0 = 16'h0016;
      tick(); bus.rd0 = 0; bus.req0 = 0;
      at_neg(); check("t1_last_rvalid0", 16'(bus.rvalid0), 16'h1);
      repeat (4) tick();

      // 2: simultaneous requests, then round-robin with an idle bubble
      do_reset();
      bus.req0 = 1; bus.req1 = 1;
      tick();
      at_neg();
      check("t2_gnt0", 16'(bus.gnt0), 16'h1);
      check("t2_gnt1_off", 16'(bus.gnt1), 16'h0);
      tick(); bus.req0 = 0;
      tick(); bus.req0 = 1;
      at_neg(); check("t2_bubble", 16'({bus.gnt1, bus.gnt0}), 16'h0);
      tick();
      at_neg(); check("t2_rr_gnt1", 16'({bus.gnt1, bus.gnt0}), 16'h2);
      tick(); bus.req0 = 0; bus.req1 = 0;
      repeat (3) tick();

      // 3: write held off by a busy bank for three cycles
      do_reset();
      bus.req0 = 1;
      tick();
      bus.wr0 = 1; bus.addr0 = 16'h0102; bus.wdata0 = 16'hBEEF; bus.m_busy = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         at_neg();
         check("t3_stall0", 16'(bus.stall0), 16'h1);
         check("t3_no_wr", 16'(bus.fm_wr), 16'h0);
         tick();
      end
      bus.m_busy = 4'b0000;
      at_neg();
      check("t3_fm_wr", 16'(bus.fm_wr), 16'h1);
      check("t3_fm_data", bus.fm_data_in, 16'hBEEF);
      check("t3_no_stall", 16'(bus.stall0), 16'h0);
      tick(); bus.wr0 = 0; bus.req0 = 0;
      repeat (2) tick();

      // 4: release with a read in flight drains, then the waiting port is served
      do_reset();
      bus.req1 = 1;
      tick();
      bus.rd1 = 1; bus.addr1 = 16'h0020; bus.req0 = 1;
      tick(); bus.rd1 = 0; bus.req1 = 0;
      tick();
      at_neg();
      check("t4_rvalid1", 16'(bus.rvalid1), 16'h1);
      check("t4_gnt_off", 16'({bus.gnt1, bus.gnt0}), 16'h0);
      tick(); tick();
      at_neg(); check("t4_idle", 16'(bus.gnt0), 16'h0);
      tick();
      at_neg(); check("t4_gnt0", 16'(bus.gnt0), 16'h1);
      tick(); bus.req0 = 0;
      repeat (2) tick();

      // 5: protocol errors and non-owner access
      do_reset();
      bus.req1 = 1;
      tick();
      bus.rd1 = 1; bus.wr1 = 1; bus.addr1 = 16'h0040;
      at_neg();
      check("t5_err", 16'(bus.err), 16'h1);
      check("t5_no_strobe", 16'({bus.fm_rd, bus.fm_wr}), 16'h0);
      check("t5_stall1", 16'(bus.stall1), 16'h1);
      tick();
      bus.rd1 = 0; bus.wr1 = 0; bus.req0 = 1; bus.rd0 = 1; bus.addr0 = 16'h0050;
      at_neg();
      check("t5_nonown_stall", 16'(bus.stall0), 16'h1);
      check("t5_nonown_rd", 16'(bus.fm_rd), 16'h0);
      check("t5_nonown_err", 16'(bus.err), 16'h0);
      tick(); bus.req0 = 0;
      at_neg(); check("t5_noreq_err", 16'(bus.err), 16'h1);
      tick(); bus.rd0 = 0; bus.req1 = 0;
      repeat (2) tick();

      // 6: watchdog, then reset in the middle of a burst
      do_reset();
      bus.req0 = 1; bus.req1 = 1;
      tick();
      repeat (63) tick();
      at_neg(); check("t6_wd_off", 16'(bus.err), 16'h0);
      tick();
      bus.rd0 = 1; bus.addr0 = 16'h0030;
      at_neg();
      check("t6_wd_on", 16'(bus.err), 16'h1);
      check("t6_rd_acc", 16'(bus.fm_rd), 16'h1);
      tick();
      rst = 1'b1;
      at_neg();
      check("t6_rst_gnt", 16'(bus.gnt0), 16'h0);
      check("t6_rst_stall", 16'(bus.stall0), 16'h0);
      check("t6_rst_err", 16'(bus.err), 16'h0);
      tick();
      rst = 1'b0; bus.rd0 = 0; bus.req0 = 0; bus.req1 = 0;
      at_neg(); check("t6_no_late", 16'(bus.rvalid0), 16'h0);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
